// File: rtl/alarm_pkg.sv
// Shared types and widths for the multi-channel alarm controller.
// Holds the FSM state encoding and the time field widths.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } alarm_state_e;

  localparam int HRS_W = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  // A single-channel build still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_if.sv
// Alarm slot write bus driven by the adjust logic.
// The adjust logic is the master; the alarm controller is the slave.
interface multi_alarm_ctrl_if
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS = 4
);
  localparam int IDXW = idx_width(NUM_ALARMS);

  logic             wr_en;
  logic [IDXW-1:0]  wr_idx;
  logic [HRS_W-1:0] wr_hrs;
  logic [MIN_W-1:0] wr_mins;
  logic             wr_arm;

  modport master (output wr_en, wr_idx, wr_hrs, wr_mins, wr_arm);
  modport slave  (input  wr_en, wr_idx, wr_hrs, wr_mins, wr_arm);
endinterface

// File: rtl/alarm_slot.sv
// One alarm channel: stored time and armed bit, write decode,
// minute-boundary match comparator and sticky missed flag.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int IDXW     = 2,
  parameter int SLOT_IDX = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [HRS_W-1:0] wr_hrs,
  input  logic [MIN_W-1:0] wr_mins,
  input  logic             wr_arm,
  input  logic             sec_tick,
  input  logic [HRS_W-1:0] cur_hrs,
  input  logic [MIN_W-1:0] cur_mins,
  input  logic [SEC_W-1:0] cur_secs,
  input  logic             suppress,
  input  logic             set_missed,
  output logic             match,
  output logic             armed,
  output logic             missed
);

  logic [HRS_W-1:0] hrs_q, hrs_d;
  logic [MIN_W-1:0] mins_q, mins_d;
  logic             armed_q, armed_d;
  logic             missed_q, missed_d;
  logic             wr_sel;

  // A write wins over a same-cycle missed event so rewriting always clears it.
  always_comb begin
    wr_sel   = wr_en && (wr_idx == IDXW'(SLOT_IDX));
    hrs_d    = hrs_q;
    mins_d   = mins_q;
    armed_d  = armed_q;
    missed_d = missed_q | set_missed;
    if (wr_sel) begin
      hrs_d    = wr_hrs;
      mins_d   = wr_mins;
      armed_d  = wr_arm;
      missed_d = 1'b0;
    end
    match = sec_tick && (cur_secs == '0) && armed_q && !suppress &&
            (hrs_q == cur_hrs) && (mins_q == cur_mins);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrs_q    <= '0;
      mins_q   <= '0;
      armed_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      hrs_q    <= hrs_d;
      mins_q   <= mins_d;
      armed_q  <= armed_d;
      missed_q <= missed_d;
    end
  end

  assign armed  = armed_q;
  assign missed = missed_q;

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-channel alarm controller: NUM_ALARMS slots feeding one shared
// ring/snooze/timeout FSM that drives the LED blink and buzzer enable.
module multi_alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  localparam int IDXW            = idx_width(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [HRS_W-1:0]      cur_hrs,
  input  logic [MIN_W-1:0]      cur_mins,
  input  logic [SEC_W-1:0]      cur_secs,
  input  logic                  suppress,
  multi_alarm_ctrl_if.slave     wr,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ringing,
  output logic                  snoozed,
  output logic [IDXW-1:0]       active_idx,
  output logic                  blink,
  output logic                  buzz_en,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] missed
);

  localparam int RING_W = $clog2(RING_TIMEOUT_SEC) + 1;
  localparam int SNZ_W  = $clog2(SNOOZE_SEC) + 1;
  localparam int SCNT_W = $clog2(MAX_SNOOZE) + 1;

  alarm_state_e          state_q, state_d;
  logic [IDXW-1:0]       act_q, act_d;
  logic [RING_W-1:0]     ring_q, ring_d;
  logic [SNZ_W-1:0]      snz_q, snz_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic                  blink_q, blink_d;
  logic [NUM_ALARMS-1:0] match, other, set_missed;
  logic [IDXW-1:0]       win_all, win_other, take_idx;
  logic                  take, timeout, fsm_live, wr_active;

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    alarm_slot #(.IDXW(IDXW), .SLOT_IDX(g)) u_slot (
      .clk(clk), .rst(rst),
      .wr_en(wr.wr_en), .wr_idx(wr.wr_idx), .wr_hrs(wr.wr_hrs),
      .wr_mins(wr.wr_mins), .wr_arm(wr.wr_arm),
      .sec_tick(sec_tick), .cur_hrs(cur_hrs), .cur_mins(cur_mins),
      .cur_secs(cur_secs), .suppress(suppress),
      .set_missed(set_missed[g]),
      .match(match[g]), .armed(armed[g]), .missed(missed[g])
    );
  end

  // Lowest-index winners, over all matches and over matches other than the owner.
  always_comb begin
    win_all   = '0;
    win_other = '0;
    other     = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      other[i] = match[i] && (act_q != IDXW'(i));
      if (match[i]) win_all = IDXW'(i);
      if (other[i]) win_other = IDXW'(i);
    end
    wr_active = wr.wr_en && (wr.wr_idx == act_q) && (state_q != IDLE);
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    ring_d     = ring_q;
    snz_d      = snz_q;
    scnt_d     = scnt_q;
    blink_d    = blink_q;
    take       = 1'b0;
    take_idx   = act_q;
    timeout    = 1'b0;
    set_missed = '0;
    fsm_live   = !suppress && !wr_active;
    if (!fsm_live) begin
      state_d = IDLE;
      blink_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|match) begin
            take     = 1'b1;
            take_idx = win_all;
          end
        end
        RINGING: begin
          if (dismiss) begin
            state_d = IDLE;
            blink_d = 1'b0;
          end else if (snooze) begin
            blink_d = 1'b0;
            if (scnt_q < SCNT_W'(MAX_SNOOZE)) begin
              scnt_d  = scnt_q + 1'b1;
              snz_d   = SNZ_W'(SNOOZE_SEC);
              state_d = SNOOZED;
            end else begin
              state_d = IDLE;
            end
          end else if (sec_tick) begin
            if (ring_q >= RING_W'(RING_TIMEOUT_SEC - 1)) begin
              timeout = 1'b1;
              state_d = IDLE;
              blink_d = 1'b0;
            end else begin
              ring_d  = ring_q + 1'b1;
              blink_d = !blink_q;
            end
          end
        end
        SNOOZED: begin
          if (dismiss) begin
            state_d = IDLE;
          end else if (sec_tick && snz_q <= SNZ_W'(1)) begin
            state_d = RINGING;
            ring_d  = '0;
          end else begin
            if (sec_tick) snz_d = snz_q - 1'b1;
            if (|other) begin
              take     = 1'b1;
              take_idx = win_other;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (take) begin
        act_d   = take_idx;
        ring_d  = '0;
        scnt_d  = '0;
        blink_d = 1'b0;
        state_d = RINGING;
      end
    end
    // Any match that does not end up owning the FSM is recorded as missed.
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (fsm_live && match[i] &&
          !(take && take_idx == IDXW'(i)) &&
          !(state_q != IDLE && act_q == IDXW'(i)))
        set_missed[i] = 1'b1;
      if (timeout && act_q == IDXW'(i))
        set_missed[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      ring_q  <= '0;
      snz_q   <= '0;
      scnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      scnt_q  <= scnt_d;
      blink_q <= blink_d;
    end
  end

  assign ringing    = (state_q == RINGING);
  assign snoozed    = (state_q == SNOOZED);
  assign active_idx = act_q;
  assign blink      = blink_q;
  assign buzz_en    = ringing && blink_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Scoreboard bench for multi_alarm_ctrl: directed scenarios then random
// traffic, all checked against an event-level model of the alarm rules.
module tb_multi_alarm_ctrl;

  localparam int NA   = 4;
  localparam int SNZ  = 300;
  localparam int TMO  = 60;
  localparam int MAXS = 3;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  typedef struct packed {
    logic       ringing;
    logic       snoozed;
    logic [1:0] act;
    logic       blink;
    logic       buzz;
    logic [3:0] armed;
    logic [3:0] missed;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sec_tick = 1'b0;
  logic       suppress = 1'b0;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic [4:0] cur_hrs = '0;
  logic [5:0] cur_mins = '0;
  logic [5:0] cur_secs = '0;
  logic       ringing, snoozed, blink, buzz_en;
  logic [1:0] active_idx;
  logic [3:0] armed, missed;

  int compared = 0;
  int mismatched = 0;
  obs_t sbq[$];

  int mHrs[NA];
  int mMins[NA];
  bit mArm[NA];
  bit mMissed[NA];
  int mode, act, ringSecs, snzLeft, snzCount;
  bit blinkM;

  multi_alarm_ctrl_if #(.NUM_ALARMS(NA)) wr_bus ();

  multi_alarm_ctrl #(
    .NUM_ALARMS(NA), .SNOOZE_SEC(SNZ), .RING_TIMEOUT_SEC(TMO), .MAX_SNOOZE(MAXS)
  ) dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick),
    .cur_hrs(cur_hrs), .cur_mins(cur_mins), .cur_secs(cur_secs),
    .suppress(suppress), .wr(wr_bus), .snooze(snooze), .dismiss(dismiss),
    .ringing(ringing), .snoozed(snoozed), .active_idx(active_idx),
    .blink(blink), .buzz_en(buzz_en), .armed(armed), .missed(missed)
  );

  always #5 clk = ~clk;

  // Model reset: everything cleared, all slots 00:00 and disarmed.
  task automatic modelReset();
    for (int i = 0; i < NA; i++) begin
      mHrs[i] = 0; mMins[i] = 0; mArm[i] = 0; mMissed[i] = 0;
    end
    mode = M_IDLE; act = 0; ringSecs = 0; snzLeft = 0; snzCount = 0; blinkM = 0;
  endtask

  // Event-level alarm rules: resolve the highest-priority event, then missed flags, then writes.
  task automatic modelStep(input bit r, input bit tk, input int h, input int m, input int s,
                           input bit sup, input bit we, input int wi, input int wh,
                           input int wm, input bit wa, input bit sn, input bit di);
    bit hit[NA];
    int took, oldMode, oldAct;
    bit writeAct;
    if (r) begin
      modelReset();
      return;
    end
    for (int i = 0; i < NA; i++)
      hit[i] = tk && (s == 0) && !sup && mArm[i] && (mHrs[i] == h) && (mMins[i] == m);
    oldMode = mode;
    oldAct = act;
    took = -1;
    writeAct = we && (wi < NA) && (mode != M_IDLE) && (wi == act);
    if (sup || writeAct) begin
      mode = M_IDLE;
      blinkM = 0;
    end else if (mode == M_IDLE) begin
      for (int i = NA - 1; i >= 0; i--) if (hit[i]) took = i;
    end else if (mode == M_RING) begin
      if (di) begin
        mode = M_IDLE; blinkM = 0;
      end else if (sn) begin
        blinkM = 0;
        if (snzCount < MAXS) begin
          snzCount++; snzLeft = SNZ; mode = M_SNZ;
        end else mode = M_IDLE;
      end else if (tk) begin
        ringSecs++;
        if (ringSecs >= TMO) begin
          mMissed[act] = 1; mode = M_IDLE; blinkM = 0;
        end else blinkM = !blinkM;
      end
    end else begin
      if (di) mode = M_IDLE;
      else begin
        if (tk) snzLeft--;
        if (tk && snzLeft == 0) begin
          mode = M_RING; ringSecs = 0;
        end else begin
          for (int i = NA - 1; i >= 0; i--) if (hit[i] && i != act) took = i;
        end
      end
    end
    if (took >= 0) begin
      act = took; ringSecs = 0; snzCount = 0; blinkM = 0; mode = M_RING;
    end
    if (!sup && !writeAct)
      for (int i = 0; i < NA; i++)
        if (hit[i] && i != took && !(oldMode != M_IDLE && i == oldAct)) mMissed[i] = 1;
    if (we && wi < NA) begin
      mHrs[wi] = wh; mMins[wi] = wm; mArm[wi] = wa; mMissed[wi] = 0;
    end
  endtask

  function automatic obs_t expectedObs();
    obs_t e;
    e.ringing = (mode == M_RING);
    e.snoozed = (mode == M_SNZ);
    e.act     = 2'(act);
    e.blink   = blinkM;
    e.buzz    = (mode == M_RING) && blinkM;
    for (int i = 0; i < NA; i++) begin
      e.armed[i]  = mArm[i];
      e.missed[i] = mMissed[i];
    end
    return e;
  endfunction

  // Drives one cycle of inputs, queues the model's post-edge outputs, returns 2 time units after the edge.
  task automatic applyStimulus(input bit tk, input int h, input int m, input int s,
                               input bit sup, input bit we, input int wi, input int wh,
                               input int wm, input bit wa, input bit sn, input bit di);
    sec_tick = tk; cur_hrs = 5'(h); cur_mins = 6'(m); cur_secs = 6'(s);
    suppress = sup; snooze = sn; dismiss = di;
    wr_bus.wr_en = we; wr_bus.wr_idx = 2'(wi); wr_bus.wr_hrs = 5'(wh);
    wr_bus.wr_mins = 6'(wm); wr_bus.wr_arm = wa;
    modelStep(rst, tk, h, m, s, sup, we, wi, wh, wm, wa, sn, di);
    sbq.push_back(expectedObs());
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic writeSlot(input int idx, input int h, input int m, input bit a);
    applyStimulus(0, 0, 0, 1, 0, 1, idx, h, m, a, 0, 0);
  endtask

  task automatic minuteTick(input int h, input int m);
    applyStimulus(1, h, m, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic plainTicks(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1, 12, 12, (k % 59) + 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin : monitor
    obs_t e;
    obs_t a;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = {ringing, snoozed, active_idx, blink, buzz_en, armed, missed};
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("[TB] FAIL scoreboard t=%0t: got ring=%b snz=%b idx=%0d blink=%b buzz=%b armed=%b missed=%b, expected ring=%b snz=%b idx=%0d blink=%b buzz=%b armed=%b missed=%b",
                 $time, a.ringing, a.snoozed, a.act, a.blink, a.buzz, a.armed, a.missed,
                 e.ringing, e.snoozed, e.act, e.blink, e.buzz, e.armed, e.missed);
      end
    end
  end

  initial begin
    wr_bus.wr_en = 0; wr_bus.wr_idx = 0; wr_bus.wr_hrs = 0; wr_bus.wr_mins = 0; wr_bus.wr_arm = 0;
    modelReset();
    rst = 1'b1;
    idleCycle();
    idleCycle();
    checkOutput("reset_ringing", int'(ringing), 0);
    checkOutput("reset_armed", int'(armed), 0);
    rst = 1'b0;

    $display("[TB] slot 2 at 07:30 rings and blinks");
    writeSlot(2, 7, 30, 1);
    minuteTick(7, 30);
    checkOutput("ring_latency", int'(ringing), 1);
    checkOutput("ring_idx", int'(active_idx), 2);
    checkOutput("blink0", int'(blink), 0);
    plainTicks(1);
    checkOutput("blink1", int'(blink), 1);
    checkOutput("buzz1", int'(buzz_en), 1);
    plainTicks(1);
    checkOutput("blink2", int'(blink), 0);

    $display("[TB] unanswered ringing times out");
    plainTicks(57);
    checkOutput("pre_timeout", int'(ringing), 1);
    plainTicks(1);
    checkOutput("timeout_idle", int'(ringing), 0);
    checkOutput("timeout_missed", int'(missed), 4'b0100);
    writeSlot(2, 7, 30, 1);
    checkOutput("rewrite_clears_missed", int'(missed), 0);

    $display("[TB] three snoozes then snooze-as-dismiss");
    minuteTick(7, 30);
    for (int n = 0; n < MAXS; n++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      checkOutput("snoozed", int'(snoozed), 1);
      plainTicks(SNZ - 1);
      checkOutput("still_snoozed", int'(snoozed), 1);
      plainTicks(1);
      checkOutput("re_ring", int'(ringing), 1);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("fourth_snooze_ring", int'(ringing), 0);
    checkOutput("fourth_snooze_snz", int'(snoozed), 0);

    $display("[TB] simultaneous matches, lowest index wins");
    writeSlot(1, 6, 0, 1);
    writeSlot(3, 6, 0, 1);
    minuteTick(6, 0);
    checkOutput("multi_idx", int'(active_idx), 1);
    checkOutput("multi_missed3", int'(missed[3]), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("[TB] pre-emption while snoozed, dismiss beats snooze");
    writeSlot(0, 5, 0, 1);
    minuteTick(5, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    minuteTick(6, 0);
    checkOutput("preempt_ring", int'(ringing), 1);
    checkOutput("preempt_idx", int'(active_idx), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("dismiss_snooze_ring", int'(ringing), 0);
    checkOutput("dismiss_snooze_snz", int'(snoozed), 0);

    $display("[TB] async reset mid-ring and suppress");
    minuteTick(6, 0);
    plainTicks(1);
    checkOutput("pre_reset_buzz", int'(buzz_en), 1);
    rst = 1'b1;
    #1;
    checkOutput("async_ringing", int'(ringing), 0);
    checkOutput("async_buzz", int'(buzz_en), 0);
    checkOutput("async_armed", int'(armed), 0);
    modelReset();
    idleCycle();
    rst = 1'b0;
    writeSlot(0, 8, 0, 1);
    applyStimulus(1, 8, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("suppress_idle", int'(ringing), 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 20000; c++) begin
      int h, m, s, wi, wh, wm;
      bit tk, sup, we, wa, sn, di;
      tk  = ($urandom_range(0, 1) == 1);
      h   = $urandom_range(6, 8);
      m   = ($urandom_range(0, 1) == 1) ? 30 : 0;
      s   = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 59);
      sup = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 59) == 0);
      wi  = $urandom_range(0, NA - 1);
      wh  = $urandom_range(6, 7);
      wm  = ($urandom_range(0, 1) == 1) ? 30 : 0;
      wa  = ($urandom_range(0, 3) != 0);
      sn  = ($urandom_range(0, 149) == 0);
      di  = ($urandom_range(0, 199) == 0);
      applyStimulus(tk, h, m, s, sup, we, wi, wh, wm, wa, sn, di);
    end
    idleCycle();
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
